// File: rtl/riscv_wb_pkg.sv
// Shared types for the writeback stage: load size encoding, load-queue entry
// layout and the misalignment rule applied when a load result retires.
package riscv_wb_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned LQ_ADDR_MAX   = 8;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  // Destination is stored at the widest supported RF address; the top truncates.
  typedef struct packed {
    logic [LQ_ADDR_MAX-1:0] waddr;
    ld_size_e               size;
    logic                   sext;
    logic [1:0]             offs;
  } lq_entry_t;

  function automatic logic is_misaligned(input ld_size_e size, input logic [1:0] offs);
    logic mis;
    case (size)
      LD_B:    mis = 1'b0;
      LD_H:    mis = (offs == 2'd3);
      LD_W:    mis = (offs != 2'd0);
      default: mis = (offs != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load alignment: shift the raw word down by the byte offset,
// then zero- or sign-extend the selected byte/half to 32 bits.
module riscv_load_align
  import riscv_wb_pkg::*;
(
  input  logic [WB_DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]               offs_i,
  input  ld_size_e                 size_i,
  input  logic                     sext_i,
  output logic [WB_DATA_WIDTH-1:0] wdata_o
);

  logic [WB_DATA_WIDTH-1:0] shifted_s;

  always_comb begin
    shifted_s = rdata_i >> {offs_i, 3'b000};
    case (size_i)
      LD_B: begin
        if (sext_i) begin
          wdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end else begin
          wdata_o = {24'h00_0000, shifted_s[7:0]};
        end
      end
      LD_H: begin
        if (sext_i) begin
          wdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end else begin
          wdata_o = {16'h0000, shifted_s[15:0]};
        end
      end
      LD_W:    wdata_o = shifted_s;
      default: wdata_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// Writeback stage: registered EX result on RF port A, in-order load queue with
// aligned results on RF port B, and a per-register busy scoreboard for decode.
module riscv_wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LQ_DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_we_i,
  input  logic [ADDR_WIDTH-1:0]     ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
  input  logic                      ld_issue_i,
  input  logic [ADDR_WIDTH-1:0]     ld_waddr_i,
  input  logic [1:0]                ld_size_i,
  input  logic                      ld_sext_i,
  input  logic [1:0]                ld_offs_i,
  input  logic                      lsu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     lsu_rdata_i,
  output logic                      ld_full_o,
  output logic [2**ADDR_WIDTH-1:0]  busy_o,
  output logic                      err_o,
  output logic [ADDR_WIDTH-1:0]     waddr_a_o,
  output logic [DATA_WIDTH-1:0]     wdata_a_o,
  output logic                      we_a_o,
  output logic [ADDR_WIDTH-1:0]     waddr_b_o,
  output logic [DATA_WIDTH-1:0]     wdata_b_o,
  output logic                      we_b_o
);

  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;
  localparam int unsigned PTR_W     = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LQ_DEPTH);

  if (DATA_WIDTH != WB_DATA_WIDTH) begin : g_bad_data_width
    $error("riscv_wb_stage: alignment logic supports DATA_WIDTH=32 only");
  end
  if (ADDR_WIDTH > LQ_ADDR_MAX) begin : g_bad_addr_width
    $error("riscv_wb_stage: ADDR_WIDTH exceeds load-queue entry width");
  end

  logic                  we_a_q, we_a_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;

  lq_entry_t             lq_q [LQ_DEPTH];
  lq_entry_t             push_entry_s, head_s;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_s, empty_s, push_ok_s, pop_ok_s;
  logic                  err_q, err_d;

  logic [NUM_WORDS-1:0]  busy_q, busy_d, busy_set_s, busy_clr_s;

  logic                  we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
  logic [DATA_WIDTH-1:0] aligned_s;
  logic                  unused_waddr_s;

  always_comb begin
    we_a_d    = ex_we_i && (ex_waddr_i != '0);
    waddr_a_d = ex_waddr_i;
    wdata_a_d = ex_wdata_i;
  end

  always_comb begin
    push_entry_s.waddr = LQ_ADDR_MAX'(ld_waddr_i);
    push_entry_s.size  = ld_size_e'(ld_size_i);
    push_entry_s.sext  = ld_sext_i;
    push_entry_s.offs  = ld_offs_i;
    head_s             = lq_q[rd_ptr_q];
  end

  assign unused_waddr_s = ^head_s.waddr;

  // A pop frees a slot in the same cycle, so a push into a full queue survives it.
  always_comb begin
    full_s    = (count_q == CNT_FULL);
    empty_s   = (count_q == '0);
    pop_ok_s  = lsu_rvalid_i && !empty_s;
    push_ok_s = ld_issue_i && (!full_s || pop_ok_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q
          | (ld_issue_i && full_s && !lsu_rvalid_i)
          | (lsu_rvalid_i && empty_s)
          | (pop_ok_s && is_misaligned(head_s.size, head_s.offs));
  end

  riscv_load_align u_align (
    .rdata_i (lsu_rdata_i),
    .offs_i  (head_s.offs),
    .size_i  (head_s.size),
    .sext_i  (head_s.sext),
    .wdata_o (aligned_s)
  );

  // Clear is applied before set so a new load to the retiring register keeps it busy.
  always_comb begin
    we_b_d     = pop_ok_s && (head_s.waddr[ADDR_WIDTH-1:0] != '0);
    waddr_b_d  = head_s.waddr[ADDR_WIDTH-1:0];
    wdata_b_d  = aligned_s;
    busy_clr_s = we_b_q ? (NUM_WORDS'(1) << waddr_b_q) : '0;
    busy_set_s = (push_ok_s && (ld_waddr_i != '0)) ? (NUM_WORDS'(1) << ld_waddr_i) : '0;
    busy_d     = (busy_q & ~busy_clr_s) | busy_set_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        lq_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      lq_q[wr_ptr_q] <= push_entry_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= '0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
    end else begin
      we_a_q    <= we_a_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign ld_full_o = full_s;

endmodule
